// File: rtl/ptr_ring_router_mc_if.sv
// Ring-lane and local-port bundle for ptr_ring_router_mc.
// slave = router side, master = neighbour/local-node side.
interface ptr_ring_router_mc_if #(
  parameter int DATA_WIDTH = 128,
  parameter int NODE_NUM   = 128,
  parameter int NUM_CH     = 4
);
  localparam int CNT_W = $clog2(NODE_NUM);

  logic [NUM_CH-1:0]            lastVld;
  logic [NUM_CH*CNT_W-1:0]      lastDestCnt;
  logic [NUM_CH*DATA_WIDTH-1:0] lastDat;
  logic [NUM_CH-1:0]            nxtVld;
  logic [NUM_CH*CNT_W-1:0]      nxtDestCnt;
  logic [NUM_CH*DATA_WIDTH-1:0] nxtDat;
  logic                         l2rWr;
  logic [CNT_W-1:0]             l2rDest;
  logic [DATA_WIDTH-1:0]        l2rDat;
  logic                         l2rFull;
  logic                         r2lRd;
  logic [DATA_WIDTH-1:0]        r2lDat;
  logic                         r2lEmpty;
  logic [7:0]                   dropCnt;
  logic [15:0]                  defCnt;

  modport slave (
    input  lastVld, lastDestCnt, lastDat,
    input  l2rWr, l2rDest, l2rDat, r2lRd,
    output nxtVld, nxtDestCnt, nxtDat,
    output l2rFull, r2lDat, r2lEmpty,
    output dropCnt, defCnt
  );

  modport master (
    output lastVld, lastDestCnt, lastDat,
    output l2rWr, l2rDest, l2rDat, r2lRd,
    input  nxtVld, nxtDestCnt, nxtDat,
    input  l2rFull, r2lDat, r2lEmpty,
    input  dropCnt, defCnt
  );
endinterface

// File: rtl/ptr_ring_router_mc.sv
// NUM_CH-lane pointer-ring hop with local inject/eject FIFOs and RR arbitration.
// Define PTR_RING_DEFLECT_STAT_EN to enable the deflection counter on defCnt.
module ptr_ring_router_mc #(
  parameter int DATA_WIDTH = 128,
  parameter int NODE_NUM   = 128,
  parameter int NUM_CH     = 4,
  parameter int INJ_DEPTH  = 8,
  parameter int EJ_DEPTH   = 8
) (
  input logic clk,
  input logic rst,
  ptr_ring_router_mc_if.slave bus
);
  localparam int CNT_W = $clog2(NODE_NUM);
  localparam int PW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int IAW   = $clog2(INJ_DEPTH);
  localparam int EAW   = $clog2(EJ_DEPTH);
  localparam int IW    = CNT_W + DATA_WIDTH;
  localparam logic [CNT_W-1:0] MAXC = CNT_W'(NODE_NUM - 1);

  logic [NUM_CH-1:0]            r_nxtVld;
  logic [NUM_CH*CNT_W-1:0]      r_nxtDestCnt;
  logic [NUM_CH*DATA_WIDTH-1:0] r_nxtDat;
  logic [IW-1:0]                r_injMem [INJ_DEPTH];
  logic [IAW:0]                 r_injWp, r_injRp;
  logic [DATA_WIDTH-1:0]        r_ejMem [EJ_DEPTH];
  logic [EAW:0]                 r_ejWp, r_ejRp;
  logic [DATA_WIDTH-1:0]        r_ejLast;
  logic [PW-1:0]                r_ejPtr, r_injPtr;
  logic [7:0]                   r_dropCnt;

  logic w_injEmpty, w_injFull, w_ejEmpty, w_ejFull;
  logic w_destOk, w_injWr, w_drop, w_ejRd, w_ejAcc;
  logic w_ejAny, w_injAny;
  logic [PW-1:0] w_ejIdx, w_injIdx;
  logic [NUM_CH-1:0] w_cand, w_busy;
  logic [IW-1:0] w_injHead;
  logic [NUM_CH-1:0]            w_vld;
  logic [NUM_CH*CNT_W-1:0]      w_dc;
  logic [NUM_CH*DATA_WIDTH-1:0] w_dat;

  assign w_injEmpty = r_injWp == r_injRp;
  assign w_injFull  = (r_injWp[IAW] != r_injRp[IAW]) &&
                      (r_injWp[IAW-1:0] == r_injRp[IAW-1:0]);
  assign w_ejEmpty  = r_ejWp == r_ejRp;
  assign w_ejFull   = (r_ejWp[EAW] != r_ejRp[EAW]) &&
                      (r_ejWp[EAW-1:0] == r_ejRp[EAW-1:0]);

  assign w_destOk = (bus.l2rDest != '0) &&
                    (32'(bus.l2rDest) < NODE_NUM);
  assign w_injWr  = bus.l2rWr && !w_injFull && w_destOk;
  assign w_drop   = bus.l2rWr && !w_injFull && !w_destOk;
  assign w_ejRd   = bus.r2lRd && !w_ejEmpty;
  assign w_injHead = r_injMem[r_injRp[IAW-1:0]];

  always_comb begin
    w_cand = '0;
    for (int i = 0; i < NUM_CH; i++)
      w_cand[i] = bus.lastVld[i] &&
                  (bus.lastDestCnt[i*CNT_W +: CNT_W] == '0);
  end

  always_comb begin
    w_ejAny = 1'b0;
    w_ejIdx = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (!w_ejAny && w_cand[(int'(r_ejPtr) + k) % NUM_CH]) begin
        w_ejAny = 1'b1;
        w_ejIdx = PW'((int'(r_ejPtr) + k) % NUM_CH);
      end
    end
  end

  // A full FIFO still accepts the winner when the local side pops this cycle
  assign w_ejAcc = w_ejAny && (!w_ejFull || bus.r2lRd);

  always_comb begin
    w_busy = '0;
    for (int i = 0; i < NUM_CH; i++)
      w_busy[i] = bus.lastVld[i] &&
                  !(w_ejAcc && (w_ejIdx == PW'(i)));
  end

  always_comb begin
    w_injAny = 1'b0;
    w_injIdx = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (!w_injEmpty && !w_injAny &&
          !w_busy[(int'(r_injPtr) + k) % NUM_CH]) begin
        w_injAny = 1'b1;
        w_injIdx = PW'((int'(r_injPtr) + k) % NUM_CH);
      end
    end
  end

  always_comb begin
    w_vld = '0;
    w_dc  = '0;
    w_dat = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_busy[i]) begin
        w_vld[i] = 1'b1;
        w_dc[i*CNT_W +: CNT_W] = w_cand[i] ? MAXC :
          bus.lastDestCnt[i*CNT_W +: CNT_W] - CNT_W'(1);
        w_dat[i*DATA_WIDTH +: DATA_WIDTH] =
          bus.lastDat[i*DATA_WIDTH +: DATA_WIDTH];
      end else if (w_injAny && (w_injIdx == PW'(i))) begin
        w_vld[i] = 1'b1;
        w_dc[i*CNT_W +: CNT_W] = w_injHead[IW-1 -: CNT_W] - CNT_W'(1);
        w_dat[i*DATA_WIDTH +: DATA_WIDTH] = w_injHead[DATA_WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_injWr)
      r_injMem[r_injWp[IAW-1:0]] <= {bus.l2rDest, bus.l2rDat};
    if (w_ejAcc)
      r_ejMem[r_ejWp[EAW-1:0]] <=
        bus.lastDat[int'(w_ejIdx)*DATA_WIDTH +: DATA_WIDTH];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_nxtVld     <= '0;
      r_nxtDestCnt <= '0;
      r_nxtDat     <= '0;
      r_injWp      <= '0;
      r_injRp      <= '0;
      r_ejWp       <= '0;
      r_ejRp       <= '0;
      r_ejLast     <= '0;
      r_ejPtr      <= '0;
      r_injPtr     <= '0;
      r_dropCnt    <= '0;
    end else begin
      r_nxtVld     <= w_vld;
      r_nxtDestCnt <= w_dc;
      r_nxtDat     <= w_dat;
      if (w_injWr)  r_injWp <= r_injWp + (IAW+1)'(1);
      if (w_injAny) r_injRp <= r_injRp + (IAW+1)'(1);
      if (w_ejAcc)  r_ejWp  <= r_ejWp + (EAW+1)'(1);
      if (w_ejRd) begin
        r_ejRp   <= r_ejRp + (EAW+1)'(1);
        r_ejLast <= r_ejMem[r_ejRp[EAW-1:0]];
      end
      if (w_ejAny)
        r_ejPtr <= PW'((int'(w_ejIdx) + 1) % NUM_CH);
      if (w_injAny)
        r_injPtr <= PW'((int'(w_injIdx) + 1) % NUM_CH);
      if (w_drop && (r_dropCnt != 8'hFF))
        r_dropCnt <= r_dropCnt + 8'd1;
    end
  end

`ifdef PTR_RING_DEFLECT_STAT_EN
  logic [15:0] r_defCnt;
  logic [16:0] w_defSum;

  always_comb begin
    w_defSum = {1'b0, r_defCnt};
    for (int i = 0; i < NUM_CH; i++)
      w_defSum = w_defSum + 17'(w_busy[i] && w_cand[i]);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_defCnt <= '0;
    else      r_defCnt <= w_defSum[16] ? 16'hFFFF : w_defSum[15:0];
  end

  assign bus.defCnt = r_defCnt;
`else
  assign bus.defCnt = '0;
`endif

  assign bus.nxtVld     = r_nxtVld;
  assign bus.nxtDestCnt = r_nxtDestCnt;
  assign bus.nxtDat     = r_nxtDat;
  assign bus.l2rFull    = w_injFull;
  assign bus.r2lEmpty   = w_ejEmpty;
  assign bus.r2lDat     = w_ejEmpty ? r_ejLast : r_ejMem[r_ejRp[EAW-1:0]];
  assign bus.dropCnt    = r_dropCnt;
endmodule

// File: tb/tb_ptr_ring_router_mc.sv
// Bench for ptr_ring_router_mc: directed table, corner sequences and
// random traffic against a queue-based router model.
module tb_ptr_ring_router_mc;
  localparam int DW  = 128;
  localparam int NN  = 128;
  localparam int NC  = 4;
  localparam int CW  = 7;
  localparam int DEP = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ptr_ring_router_mc_if #(.DATA_WIDTH(DW), .NODE_NUM(NN), .NUM_CH(NC)) bus();

  ptr_ring_router_mc #(
    .DATA_WIDTH(DW), .NODE_NUM(NN), .NUM_CH(NC),
    .INJ_DEPTH(DEP), .EJ_DEPTH(DEP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [DW-1:0] dat;
    int dest;
  } inj_t;

  inj_t          injQ[$];
  logic [DW-1:0] ejQ[$];
  bit            m_v[NC];
  int            m_dc[NC];
  logic [DW-1:0] m_dat[NC];
  logic [DW-1:0] m_last;
  int m_ejPtr, m_injPtr, m_drop, m_def;

  task automatic chk(string nm, logic [DW-1:0] a, logic [DW-1:0] e);
    n_vec++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s act=%0h exp=%0h", nm, a, e);
    end
  endtask

  task automatic model_reset();
    injQ.delete();
    ejQ.delete();
    for (int i = 0; i < NC; i++) begin
      m_v[i] = 0; m_dc[i] = 0; m_dat[i] = '0;
    end
    m_last = '0;
    m_ejPtr = 0; m_injPtr = 0; m_drop = 0; m_def = 0;
  endtask

  // Next-state of the router from the current inputs, in queue terms
  task automatic model_step();
    int win, dc, ndef;
    bit acc, injFullPre;
    bit nv[NC];
    int ndc[NC];
    logic [DW-1:0] nd[NC];
    win = -1;
    for (int k = 0; k < NC; k++) begin
      int j;
      j = (m_ejPtr + k) % NC;
      if (bus.lastVld[j] && bus.lastDestCnt[j*CW +: CW] == 0) begin
        win = j;
        break;
      end
    end
    acc = (win >= 0) && (ejQ.size() < DEP || bus.r2lRd);
    if (win >= 0) m_ejPtr = (win + 1) % NC;
    ndef = 0;
    for (int i = 0; i < NC; i++) begin
      nv[i] = 0; ndc[i] = 0; nd[i] = '0;
      if (bus.lastVld[i] && !(acc && i == win)) begin
        dc = int'(bus.lastDestCnt[i*CW +: CW]);
        nv[i] = 1;
        nd[i] = bus.lastDat[i*DW +: DW];
        if (dc == 0) begin
          ndc[i] = NN - 1;
          ndef++;
        end else ndc[i] = dc - 1;
      end
    end
    injFullPre = injQ.size() == DEP;
    if (injQ.size() > 0) begin
      for (int k = 0; k < NC; k++) begin
        int j;
        j = (m_injPtr + k) % NC;
        if (!nv[j]) begin
          nv[j] = 1;
          ndc[j] = injQ[0].dest - 1;
          nd[j] = injQ[0].dat;
          injQ.delete(0);
          m_injPtr = (j + 1) % NC;
          break;
        end
      end
    end
    if (bus.l2rWr && !injFullPre) begin
      if (bus.l2rDest != 0 && int'(bus.l2rDest) < NN)
        injQ.push_back('{dat: bus.l2rDat, dest: int'(bus.l2rDest)});
      else if (m_drop < 255) m_drop++;
    end
    if (bus.r2lRd && ejQ.size() > 0) m_last = ejQ.pop_front();
    if (acc) ejQ.push_back(bus.lastDat[win*DW +: DW]);
    m_def = (m_def + ndef > 65535) ? 65535 : m_def + ndef;
    m_v = nv; m_dc = ndc; m_dat = nd;
  endtask

  task automatic check_all();
    logic [NC-1:0] ev;
    int expDef;
    for (int i = 0; i < NC; i++) ev[i] = m_v[i];
    chk("m.nxtVld", bus.nxtVld, ev);
    for (int i = 0; i < NC; i++)
      if (m_v[i]) begin
        chk($sformatf("m.dc%0d", i), bus.nxtDestCnt[i*CW +: CW], m_dc[i]);
        chk($sformatf("m.dat%0d", i), bus.nxtDat[i*DW +: DW], m_dat[i]);
      end
    chk("m.l2rFull", bus.l2rFull, injQ.size() == DEP);
    chk("m.r2lEmpty", bus.r2lEmpty, ejQ.size() == 0);
    chk("m.r2lDat", bus.r2lDat, ejQ.size() > 0 ? ejQ[0] : m_last);
    chk("m.dropCnt", bus.dropCnt, m_drop);
`ifdef PTR_RING_DEFLECT_STAT_EN
    expDef = m_def;
`else
    expDef = 0;
`endif
    chk("m.defCnt", bus.defCnt, expDef);
  endtask

  task automatic cyc(logic [NC-1:0] v, logic [NC*CW-1:0] dc,
                     logic [NC*DW-1:0] d, bit wr, logic [CW-1:0] dest,
                     logic [DW-1:0] ld, bit rd);
    bus.lastVld = v; bus.lastDestCnt = dc; bus.lastDat = d;
    bus.l2rWr = wr; bus.l2rDest = dest; bus.l2rDat = ld; bus.r2lRd = rd;
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  function automatic logic [NC*CW-1:0] pk(int a3, int a2, int a1, int a0);
    return {CW'(a3), CW'(a2), CW'(a1), CW'(a0)};
  endfunction

  function automatic logic [NC*DW-1:0] lanes(logic [DW-1:0] b);
    logic [NC*DW-1:0] r;
    for (int i = 0; i < NC; i++) r[i*DW +: DW] = b + (DW'(i) << 16);
    return r;
  endfunction

  function automatic logic [NC*CW-1:0] vmask(logic [NC-1:0] v);
    logic [NC*CW-1:0] r;
    r = '0;
    for (int i = 0; i < NC; i++) if (v[i]) r[i*CW +: CW] = '1;
    return r;
  endfunction

  typedef struct {
    logic [NC-1:0]    v;
    logic [NC*CW-1:0] dc;
    logic [DW-1:0]    dat;
    bit               wr;
    logic [CW-1:0]    dest;
    logic [DW-1:0]    ld;
    bit               rd;
    logic [NC-1:0]    e_v;
    logic [NC*CW-1:0] e_dc;
    bit               e_empty;
    logic [DW-1:0]    e_r2l;
    int               e_drop;
  } vec_t;

  vec_t tbl[6];

  initial begin
    tbl[0] = '{4'b0100, pk(0,5,0,0), 'hA5, 0, 0, 0, 0,
               4'b0100, pk(0,4,0,0), 1, 'h0, 0};
    tbl[1] = '{4'b1001, pk(0,0,0,0), 'h11, 0, 0, 0, 0,
               4'b1000, pk(127,0,0,0), 0, 'h11, 0};
    tbl[2] = '{4'b1111, pk(10,10,10,10), 'h22, 1, 3, 'hBEEF, 0,
               4'b1111, pk(9,9,9,9), 0, 'h11, 0};
    tbl[3] = '{4'b1101, pk(10,10,10,10), 'h33, 0, 0, 0, 0,
               4'b1111, pk(9,9,2,9), 0, 'h11, 0};
    tbl[4] = '{4'b0000, pk(0,0,0,0), 'h44, 1, 0, 'hDEAD, 1,
               4'b0000, pk(0,0,0,0), 1, 'h11, 1};
    tbl[5] = '{4'b0000, pk(0,0,0,0), 'h55, 0, 0, 0, 1,
               4'b0000, pk(0,0,0,0), 1, 'h11, 1};

    rst = 1'b0;
    bus.lastVld = '0; bus.lastDestCnt = '0; bus.lastDat = '0;
    bus.l2rWr = 1'b0; bus.l2rDest = '0; bus.l2rDat = '0; bus.r2lRd = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst.nxtVld", bus.nxtVld, 0);
    chk("rst.nxtDestCnt", bus.nxtDestCnt, 0);
    chk("rst.nxtDat", bus.nxtDat[DW-1:0], 0);
    chk("rst.l2rFull", bus.l2rFull, 0);
    chk("rst.r2lEmpty", bus.r2lEmpty, 1);
    chk("rst.r2lDat", bus.r2lDat, 0);
    chk("rst.dropCnt", bus.dropCnt, 0);
    chk("rst.defCnt", bus.defCnt, 0);
    rst = 1'b1;

    foreach (tbl[r]) begin
      cyc(tbl[r].v, tbl[r].dc, lanes(tbl[r].dat), tbl[r].wr,
          tbl[r].dest, tbl[r].ld, tbl[r].rd);
      chk($sformatf("tbl%0d.vld", r), bus.nxtVld, tbl[r].e_v);
      chk($sformatf("tbl%0d.dc", r),
          bus.nxtDestCnt & vmask(tbl[r].e_v), tbl[r].e_dc);
      chk($sformatf("tbl%0d.empty", r), bus.r2lEmpty, tbl[r].e_empty);
      chk($sformatf("tbl%0d.r2l", r), bus.r2lDat, tbl[r].e_r2l);
      chk($sformatf("tbl%0d.drop", r), bus.dropCnt, tbl[r].e_drop);
    end

    // Injection FIFO fills while the ring is saturated
    for (int i = 0; i < 9; i++) begin
      cyc(4'hF, pk(50,50,50,50), lanes(DW'(i)), 1, 5, DW'('h100 + i), 0);
      if (i >= 7) chk("inj.full", bus.l2rFull, 1);
    end
    for (int i = 0; i < 9; i++)
      cyc(4'h0, '0, '0, 0, 0, 0, 0);
    chk("inj.drained", bus.nxtVld, 0);
    chk("inj.notfull", bus.l2rFull, 0);

    // Ejection FIFO full: deflect, then accept with a same-cycle pop
    for (int i = 0; i < 8; i++)
      cyc(4'b0001, '0, lanes(DW'('h200 + i)), 0, 0, 0, 0);
    chk("ej.filled", bus.r2lEmpty, 0);
    cyc(4'b0001, '0, lanes('h300), 0, 0, 0, 0);
    chk("ej.defl.vld", bus.nxtVld[0], 1);
    chk("ej.defl.dc", bus.nxtDestCnt[CW-1:0], 127);
    cyc(4'b0001, '0, lanes('h301), 0, 0, 0, 1);
    chk("ej.poppush.vld", bus.nxtVld[0], 0);
    chk("ej.poppush.head", bus.r2lDat, 'h201);
    cyc(4'b0001, '0, lanes('h302), 0, 0, 0, 0);
    chk("ej.stillfull", bus.nxtVld[0], 1);
    for (int i = 0; i < 9; i++)
      cyc(4'h0, '0, '0, 0, 0, 0, 1);
    chk("ej.drained", bus.r2lEmpty, 1);

    // Async reset in the middle of a cycle with traffic
    cyc(4'hF, pk(3,3,3,0), lanes('h400), 1, 0, 0, 0);
    #2;
    rst = 1'b0;
    #1;
    chk("arst.nxtVld", bus.nxtVld, 0);
    chk("arst.r2lEmpty", bus.r2lEmpty, 1);
    chk("arst.dropCnt", bus.dropCnt, 0);
    chk("arst.defCnt", bus.defCnt, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;

    for (int n = 0; n < 3000; n++) begin
      logic [NC*CW-1:0] rdc;
      logic [NC*DW-1:0] rdat;
      for (int i = 0; i < NC; i++) begin
        rdc[i*CW +: CW] = ($urandom_range(0, 3) == 0) ? '0 :
                          CW'($urandom_range(0, NN - 1));
        rdat[i*DW +: DW] = {$urandom, $urandom, $urandom, $urandom};
      end
      cyc(NC'($urandom), rdc, rdat, 1'($urandom),
          ($urandom_range(0, 7) == 0) ? '0 : CW'($urandom_range(1, NN - 1)),
          {$urandom, $urandom, $urandom, $urandom}, 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
